// File: rtl/i2s_tx_param_if.sv
// i2s_tx_param_if: sample stream and serial audio bundle for i2s_tx_param.
//   master : audio source / bench side (drives samples and format controls)
//   slave  : transmitter side (drives s_ready, clocks, serial data, status pulses)
// Signals: s_valid/s_ready/s_l/s_r frame handshake, fmt/mute controls,
//          mclk/sclk/lrck/sdout serial outputs, frame_start/underrun pulses.
interface i2s_tx_param_if #(
  parameter int DATA_W = 24
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_l;
  logic [DATA_W-1:0] s_r;
  logic              fmt;
  logic              mute;
  logic              mclk;
  logic              sclk;
  logic              lrck;
  logic              sdout;
  logic              frame_start;
  logic              underrun;

  modport master (
    output s_valid, s_l, s_r, fmt, mute,
    input  s_ready, mclk, sclk, lrck, sdout, frame_start, underrun
  );

  modport slave (
    input  s_valid, s_l, s_r, fmt, mute,
    output s_ready, mclk, sclk, lrck, sdout, frame_start, underrun
  );
endinterface

// File: rtl/i2s_tx_param.sv
// i2s_tx_param: parametrised I2S / left-justified stereo transmitter.
// A small frame FIFO accepts {left,right} pairs over valid/ready; once per
// frame the head is moved into shadow registers and shifted out MSB first.
// Ports:
//   clk   - system clock, forwarded as mclk
//   reset - asynchronous active-low reset
//   bus   - i2s_tx_param_if.slave (handshake, fmt/mute, serial outputs, pulses)
module i2s_tx_param #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int SCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  i2s_tx_param_if.slave  bus
);
  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int BIT_W = $clog2(2*SLOT_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } frame_t;

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [PTR_W-1:0] wp_q, rp_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  frame_t           mem_q [FIFO_DEPTH];
  frame_t           sh_q, sh_d;
  logic             running_q, first_q, fmt_q, fmt_d;
  logic             sclk_q, lrck_q, sdout_q, fs_q, ur_q;
  logic             wrap, load, empty, full, push, pop, s_ready, sd_nxt;

  function automatic logic [BIT_W-1:0] slot_pos(input logic [BIT_W-1:0] b);
    return (b >= BIT_W'(SLOT_W)) ? b - BIT_W'(SLOT_W) : b;
  endfunction

  // Left-justified bit at slot position p; positions past the word are 0.
  function automatic logic lj_bit(input logic [DATA_W-1:0] w, input logic [BIT_W-1:0] p);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (p == BIT_W'(i)) b = w[DATA_W-1-i];
    return b;
  endfunction

  assign wrap    = (div_q == DIV_W'(SCLK_DIV-1));
  assign load    = wrap && (bit_q == BIT_W'(2*SLOT_W-1));
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign s_ready = running_q && !full;
  assign push    = bus.s_valid && s_ready;
  assign pop     = load && !empty;

  always_comb begin
    div_d = wrap ? '0 : div_q + 1'b1;
    bit_d = load ? '0 : (wrap ? bit_q + 1'b1 : bit_q);
    fmt_d = load ? bus.fmt : fmt_q;
    sh_d  = sh_q;
    if (load) sh_d = (pop && !bus.mute) ? mem_q[rp_q] : '0;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Left-justified: the bit for the position being entered, from the
    // (possibly just-loaded) shadows. I2S: the bit of the position being
    // left, which yields the one-SCLK delay and carries the previous slot's
    // last bit into position 0.
    if (fmt_d)
      sd_nxt = lj_bit((bit_d >= BIT_W'(SLOT_W)) ? sh_d.r : sh_d.l, slot_pos(bit_d));
    else
      sd_nxt = lj_bit((bit_q >= BIT_W'(SLOT_W)) ? sh_q.r : sh_q.l, slot_pos(bit_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      bit_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      running_q <= 1'b0;
      first_q   <= 1'b1;
      fmt_q     <= 1'b0;
      sclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      sdout_q   <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      fmt_q     <= fmt_d;
      running_q <= 1'b1;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      if (load) first_q <= 1'b0;
      // Registered from next-state so each output equals its counter decode.
      sclk_q    <= (div_d >= DIV_W'(SCLK_DIV/2));
      lrck_q    <= (bit_d >= BIT_W'(SLOT_W));
      if (wrap) sdout_q <= sd_nxt;
      fs_q      <= load;
      // The first load after reset follows the zeroed power-up frame and is
      // not reported as an underrun.
      ur_q      <= load && empty && !first_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= '{l: bus.s_l, r: bus.s_r};
  end

  assign bus.s_ready     = s_ready;
  assign bus.mclk        = clk;
  assign bus.sclk        = sclk_q;
  assign bus.lrck        = lrck_q;
  assign bus.sdout       = sdout_q;
  assign bus.frame_start = fs_q;
  assign bus.underrun    = ur_q;
endmodule

// File: tb/tb_i2s_tx_param.sv
module tb_i2s_tx_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2s_tx_param_if #(.DATA_W(24)) bus ();
  i2s_tx_param #(.DATA_W(24), .SLOT_W(32), .SCLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until frame_start is seen at a falling edge.
  task automatic wait_fs(output int n);
    n = 0;
    while (bus.frame_start !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("fs_seen", 64'(bus.frame_start), 64'd1);
  endtask

  // Called on the falling edge where frame_start is high; records 64 bits
  // (one per SCLK period) and ends on the next frame_start edge.
  task automatic capture(input string tag, output logic [31:0] l, output logic [31:0] r,
                         output logic ur);
    int lerr;
    lerr = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < 32) l[31-i] = bus.sdout;
      else        r[63-i] = bus.sdout;
      if (bus.lrck !== (i >= 32)) lerr++;
      repeat (4) @(negedge clk);
    end
    chk({tag, "_lrck"}, 64'(lerr), 64'd0);
    chk({tag, "_period"}, 64'(bus.frame_start), 64'd1);
    ur = bus.underrun;
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r, output int tries);
    bus.s_l = l;
    bus.s_r = r;
    bus.s_valid = 1'b1;
    tries = 0;
    while (bus.s_ready !== 1'b1 && tries < 600) begin
      @(negedge clk);
      tries++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  logic [31:0] l, r, la, ra;
  logic        ur, ua;
  int          n, t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0; bus.s_l = '0; bus.s_r = '0; bus.fmt = 1'b1; bus.mute = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 64'(bus.sclk), 64'd0);
    chk("rst_lrck", 64'(bus.lrck), 64'd0);
    chk("rst_sdout", 64'(bus.sdout), 64'd0);
    chk("rst_fs", 64'(bus.frame_start), 64'd0);
    chk("rst_ur", 64'(bus.underrun), 64'd0);
    chk("rst_ready", 64'(bus.s_ready), 64'd0);
    reset = 1'b1;

    // Idle: SCLK period 4, 50% duty; first load after 256 clk.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("sclk_duty", 64'(bus.sclk), 64'((k % 4) >= 2));
      if (k == 1) begin
        chk("ready_after_rst", 64'(bus.s_ready), 64'd1);
        chk("mclk_eq_clk", 64'(bus.mclk), 64'(clk));
      end
    end
    wait_fs(n);
    chk("first_load_cycle", 64'(n + 8), 64'd256);
    chk("first_load_no_ur", 64'(bus.underrun), 64'd0);
    capture("idle", l, r, ur);
    chk("idle_data", {l, r}, 64'd0);
    chk("idle_ur_second", 64'(ur), 64'd1);

    // Left-justified.
    push(24'h800001, 24'h7FFFFF, t);
    chk("lj_push_tries", 64'(t), 64'd0);
    wait_fs(n);
    chk("lj_no_ur", 64'(bus.underrun), 64'd0);
    capture("lj", l, r, ur);
    chk("lj_left", 64'(l), 64'h80000100);
    chk("lj_right", 64'(r), 64'h7FFFFF00);
    chk("lj_ur_after", 64'(ur), 64'd1);

    // I2S: one-bit delay, position 0 carries a zero pad bit.
    bus.fmt = 1'b0;
    push(24'h800001, 24'h7FFFFF, t);
    wait_fs(n);
    capture("i2s", l, r, ur);
    chk("i2s_left", 64'(l), 64'h40000080);
    chk("i2s_right", 64'(r), 64'h3FFFFF80);

    // Fill the FIFO; the fifth frame waits for the next load's pop.
    bus.fmt = 1'b1;
    fork
      begin
        push(24'h123456, 24'hABCDEF, t); chk("fill_t1", 64'(t), 64'd0);
        push(24'h00000F, 24'hF00000, t); chk("fill_t2", 64'(t), 64'd0);
        push(24'h555555, 24'hAAAAAA, t); chk("fill_t3", 64'(t), 64'd0);
        push(24'h000001, 24'h800000, t); chk("fill_t4", 64'(t), 64'd0);
        chk("full_not_ready", 64'(bus.s_ready), 64'd0);
        push(24'hFFFFFF, 24'h000000, t);
        chk("held_until_load", 64'(t), 64'd252);
      end
      begin
        @(negedge clk);
        wait_fs(n);
        capture("fa", la, ra, ua); chk("order_a", {la, ra}, 64'h12345600ABCDEF00);
        capture("fb", la, ra, ua); chk("order_b", {la, ra}, 64'h00000F00F0000000);
        capture("fc", la, ra, ua); chk("order_c", {la, ra}, 64'h55555500AAAAAA00);
        capture("fd", la, ra, ua); chk("order_d", {la, ra}, 64'h0000010080000000);
        chk("order_e_present", 64'(ua), 64'd0);
      end
    join

    // Mute sampled at load only.
    push(24'h111111, 24'h222222, t);
    push(24'h333333, 24'h444444, t);
    push(24'h5A5A5A, 24'hA5A5A5, t);
    wait_fs(n);
    fork
      capture("mf", l, r, ur);
      begin repeat (100) @(negedge clk); bus.mute = 1'b1; end
    join
    chk("mute_cur_unmuted", {l, r}, 64'h1111110022222200);
    fork
      capture("mg", l, r, ur);
      begin repeat (100) @(negedge clk); bus.mute = 1'b0; end
    join
    chk("mute_frame_zero", {l, r}, 64'd0);
    chk("mute_next_queued", 64'(ur), 64'd0);
    capture("mh", l, r, ur);
    chk("unmute_next", {l, r}, 64'h5A5A5A00A5A5A500);
    chk("mute_popped", 64'(ur), 64'd1);

    // Reset mid right slot with three frames queued.
    push(24'h7E7E7E, 24'h818181, t);
    push(24'h0F0F0F, 24'hF0F0F0, t);
    push(24'h3C3C3C, 24'hC3C3C3, t);
    repeat (200) @(negedge clk);
    chk("pre_rst_right", 64'(bus.lrck), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_outs", {58'd0, bus.sclk, bus.lrck, bus.sdout, bus.frame_start,
                      bus.underrun, bus.s_ready}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("arst_ready", 64'(bus.s_ready), 64'd1);
    wait_fs(n);
    chk("arst_first_load", 64'(n + 1), 64'd256);
    chk("arst_no_ur", 64'(bus.underrun), 64'd0);
    capture("ar", l, r, ur);
    chk("arst_discarded", {l, r}, 64'd0);
    chk("arst_empty", 64'(ur), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_tx_param.md
# i2s_tx_param

Parametrised I2S/left-justified stereo transmitter with a frame FIFO and valid/ready sample input. It replaces the fixed-format serializer between the audio source and the codec. It generates SCLK/LRCK from the system clock with a programmable divider, and supports configurable sample and slot widths, per-frame format select, mute, and underrun reporting.

## Interface
Parameters:
- DATA_W, 24: sample width in bits, two's complement.
- SLOT_W, 32: SCLK periods per channel slot. Must be ≥ DATA_W.
- SCLK_DIV, 4: clk cycles per SCLK period. Even, ≥ 2.
- FIFO_DEPTH, 4: stereo frames buffered. Power of two, ≥ 2.

Ports:
- clk, in, 1: system clock. Also forwarded as MCLK.
- reset, in, 1: asynchronous, active-low reset.
- s_valid, in, 1: input frame valid.
- s_ready, out, 1: FIFO can accept a frame.
- s_l, in, DATA_W: left sample.
- s_r, in, DATA_W: right sample.
- fmt, in, 1: 0 = I2S (one-bit delay), 1 = left-justified.
- mute, in, 1: zero the output data.
- mclk, out, 1: equal to clk.
- sclk, out, 1: serial bit clock.
- lrck, out, 1: word clock. 0 = left, 1 = right.
- sdout, out, 1: serial data.
- frame_start, out, 1: one-clk pulse on each frame load.
- underrun, out, 1: one-clk pulse when a frame load finds the FIFO empty.

## Operation
- **Counters.**
  - div counts 0..SCLK_DIV-1 and wraps.
  - bitcnt counts 0..2*SLOT_W-1 and advances when div wraps.
- **Clocks and data.**
  - sclk = (div ≥ SCLK_DIV/2). SCLK falls at the div wrap, and sdout changes only there.
  - lrck = (bitcnt ≥ SLOT_W) in both formats.
- **Slot data.** Slot position p = bitcnt mod SLOT_W.
  - Left-justified: sdout = word bit DATA_W-1-p for p < DATA_W, else 0.
  - I2S: every bit is delayed one SCLK. Position 0 carries the previous slot's final bit (0 when SLOT_W > DATA_W). The MSB is at position 1.
- **FIFO.**
  - Each entry is {s_l, s_r}.
  - A push occurs when s_valid && s_ready.
  - s_ready = running && !full. running is a flop reset to 0 and set 1 on the first clk after reset release.
  - A push while full is impossible because s_ready is low. A simultaneous pop does not raise s_ready in the same cycle.
- **Frame load.** The load cycle is div==SCLK_DIV-1 && bitcnt==2*SLOT_W-1.
  - frame_start pulses.
  - fmt and mute are sampled.
  - If the FIFO is non-empty, the head is popped into the L/R shadow registers, forced to 0 if mute.
  - If the FIFO is empty, the shadows load 0 and underrun pulses.
  - A pop and a push in the same cycle are both honoured; the count is unchanged.
- **Format changes.** fmt and mute changes between loads have no effect until the next load.
- **After reset.** The first frame outputs zeros from zeroed shadows, with no underrun for that frame.

## Timing
- Reset values:
  - sclk, lrck, sdout, frame_start, underrun, s_ready = 0.
  - div = 0, bitcnt = 0, FIFO empty, shadows = 0.
- Reset assertion mid-frame clears everything asynchronously. Queued frames are discarded.
- Outputs sclk, lrck and sdout come directly from flops and are glitch-free.
- Frame period = 2*SLOT_W*SCLK_DIV clk. Default: 256 clk, so fs = clk/256.
- First load occurs at clk cycle 2*SLOT_W*SCLK_DIV-1 after reset release (cycle 0 = first clk edge with reset high).
- A frame pushed at least one cycle before a load is transmitted starting on the next clk after that load.
- Latency from push into an empty FIFO to the first data bit: at most one frame period + 1 clk.

## Test plan
1. Reset, then idle with s_valid=0 (defaults, fmt=1):
   - sclk has period 4 with 50% duty.
   - lrck toggles every 128 clk.
   - sdout stays 0.
   - frame_start every 256 clk.
   - underrun pulses from the second load onward.
2. fmt=1, push L=0x800001, R=0x7FFFFF:
   - Left slot bits 0..31 = 1, 22×0, 1, 8×0.
   - Right slot = 0, 23×1, 8×0.
   - No underrun on that load.
3. Same data with fmt=0:
   - Left slot position 0 = 0, MSB 1 at position 1, LSB 1 at position 24.
   - Right MSB 0 at right position 1.
   - lrck edges are identical to scenario 2.
4. Push 5 frames back-to-back at 0 frames/period drain:
   - s_ready drops after the 4th accepted push (FIFO_DEPTH=4).
   - The 5th is held until the next load, then accepted.
   - Output order is the same as push order.
5. mute=1 asserted mid-frame with data queued:
   - The current frame completes unmuted.
   - The next frame is all zeros while the FIFO still pops (count decrements).
   - After mute=0, the following frame carries the next queued samples.
6. Assert reset in the middle of a right slot with 3 frames queued:
   - All outputs 0 immediately.
   - After release, s_ready=1 on the second clk.
   - The first frame is zeros.
   - The previously queued samples never appear.
